// File: rtl/regfile_sequencer.sv
// -----------------------------------------------------------------------------
// regfile_sequencer
//   Command-driven initiator for an 8-entry register file (R1-R4, S1-S4).
//   It accepts one register operation at a time on a valid/ready command port
//   and drives the register-file control pins to carry it out. Read results come
//   back on a valid/ready response port. Only one operation is in flight at a
//   time.
//
//   Optional feature: define RFSEQ_WRITE_PROTECT_EN to add the wp_mask[7:0]
//   input. Bit n protects index n. The mask is sampled when a command is
//   accepted. An operation that would write a protected index skips the write,
//   still performs its reads, and responds with rsp_err=1 and rsp_data=0.
//
// Ports
//   clock, reset              rising-edge clock; synchronous active-high reset
//   cmd_valid/cmd_ready       command handshake
//   cmd_op[2:0]               000 LOAD 001 CLEAR 010 INC 011 DEC
//                             100 READ 101 MOVE 110 SWAP 111 reserved
//   cmd_dst/cmd_src[2:0]      index 0-3 = R1-R4, 4-7 = S1-S4
//   cmd_data                  LOAD immediate
//   wp_mask[7:0]              write-protect mask (RFSEQ_WRITE_PROTECT_EN only)
//   rsp_valid/rsp_ready       response handshake
//   rsp_data                  READ value, 0 for every other op
//   rsp_err                   reserved op or protected write
//   rf_i                      register file data input
//   rf_regsel/rf_scrsel[3:0]  R / S write enables (bit3 = R1/S1)
//   rf_funsel[2:0]            000 DEC 001 INC 010 LOAD 011 CLEAR
//   rf_outasel/rf_outbsel     read port indices
//   rf_outa/rf_outb           register file read data
// -----------------------------------------------------------------------------
module regfile_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int READ_LAT   = 1   // legal 1..4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_op,
  input  logic [2:0]            cmd_dst,
  input  logic [2:0]            cmd_src,
  input  logic [DATA_WIDTH-1:0] cmd_data,
`ifdef RFSEQ_WRITE_PROTECT_EN
  input  logic [7:0]            wp_mask,
`endif
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_err,
  output logic [DATA_WIDTH-1:0] rf_i,
  output logic [3:0]            rf_regsel,
  output logic [3:0]            rf_scrsel,
  output logic [2:0]            rf_funsel,
  output logic [2:0]            rf_outasel,
  output logic [2:0]            rf_outbsel,
  input  logic [DATA_WIDTH-1:0] rf_outa,
  input  logic [DATA_WIDTH-1:0] rf_outb
);

  // Command opcodes
  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_CLEAR = 3'b001;
  localparam logic [2:0] OP_INC   = 3'b010;
  localparam logic [2:0] OP_DEC   = 3'b011;
  localparam logic [2:0] OP_READ  = 3'b100;
  localparam logic [2:0] OP_MOVE  = 3'b101;
  localparam logic [2:0] OP_SWAP  = 3'b110;
  localparam logic [2:0] OP_RSVD  = 3'b111;

  // Register file function select codes
  localparam logic [2:0] FS_DEC   = 3'b000;
  localparam logic [2:0] FS_INC   = 3'b001;
  localparam logic [2:0] FS_LOAD  = 3'b010;
  localparam logic [2:0] FS_CLEAR = 3'b011;

  // Sequencer states
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_EXEC    = 3'd1;
  localparam logic [2:0] ST_RD_WAIT = 3'd2;
  localparam logic [2:0] ST_WR_A    = 3'd3;
  localparam logic [2:0] ST_WR_B    = 3'd4;
  localparam logic [2:0] ST_RESP    = 3'd5;

  logic [2:0]            r_state;
  logic [2:0]            r_op;
  logic [2:0]            r_dst;
  logic [2:0]            r_src;
  logic [2:0]            r_cnt;
  logic                  r_wp_hit;
  logic [DATA_WIDTH-1:0] r_b;
  logic                  w_accept;
  logic                  w_wp_hit;

  // The {regsel, scrsel} concatenation puts index k at bit 7-k for both halves,
  // so a single shift produces the one-hot enable.
  function automatic logic [7:0] idx_onehot(input logic [2:0] idx);
    return 8'h80 >> idx;
  endfunction

  function automatic logic [2:0] op_funsel(input logic [2:0] op);
    case (op)
      OP_LOAD:  return FS_LOAD;
      OP_CLEAR: return FS_CLEAR;
      OP_INC:   return FS_INC;
      default:  return FS_DEC;
    endcase
  endfunction

  assign w_accept = cmd_valid && cmd_ready;

`ifdef RFSEQ_WRITE_PROTECT_EN
  // A SWAP writes both of its indices, so either one being protected blocks it.
  always_comb begin
    // NOTE: the default assignment first means every path drives w_wp_hit, so no latch is inferred.
    w_wp_hit = 1'b0;
    case (cmd_op)
      OP_LOAD, OP_CLEAR, OP_INC, OP_DEC, OP_MOVE: w_wp_hit = wp_mask[cmd_dst];
      OP_SWAP: w_wp_hit = wp_mask[cmd_dst] | wp_mask[cmd_src];
      default: w_wp_hit = 1'b0;
    endcase
  end
`else
  assign w_wp_hit = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_op       <= OP_LOAD;
      r_dst      <= '0;
      r_src      <= '0;
      r_cnt      <= '0;
      r_wp_hit   <= 1'b0;
      r_b        <= '0;
      cmd_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
      rf_i       <= '0;
      rf_regsel  <= '0;
      rf_scrsel  <= '0;
      rf_funsel  <= '0;
      rf_outasel <= '0;
      rf_outbsel <= '0;
    end else begin
      // NOTE: non-blocking assignments let this default be overridden later in the
      //       same block, so write enables are one-cycle pulses unless a state re-arms them.
      rf_regsel <= '0;
      rf_scrsel <= '0;

      case (r_state)
        ST_IDLE: begin
          cmd_ready <= 1'b1;
          if (w_accept) begin
            cmd_ready <= 1'b0;
            r_op      <= cmd_op;
            r_dst     <= cmd_dst;
            r_src     <= cmd_src;
            r_wp_hit  <= w_wp_hit;
            case (cmd_op)
              OP_LOAD, OP_CLEAR, OP_INC, OP_DEC: begin
                if (!w_wp_hit) {rf_regsel, rf_scrsel} <= idx_onehot(cmd_dst);
                rf_funsel <= op_funsel(cmd_op);
                if (cmd_op == OP_LOAD) rf_i <= cmd_data;
                r_state <= ST_EXEC;
              end
              OP_READ, OP_MOVE, OP_SWAP: begin
                rf_outasel <= cmd_src;
                if (cmd_op == OP_SWAP) rf_outbsel <= cmd_dst;
                r_cnt   <= 3'(READ_LAT);
                r_state <= ST_RD_WAIT;
              end
              default: r_state <= ST_EXEC;  // reserved op: no register file activity
            endcase
          end
        end

        ST_EXEC: begin
          rsp_valid <= 1'b1;
          rsp_data  <= '0;
          rsp_err   <= (r_op == OP_RSVD) || r_wp_hit;
          r_state   <= ST_RESP;
        end

        // Waits READ_LAT+1 cycles so the read port has settled on the new
        // selects before the data is captured.
        ST_RD_WAIT: begin
          if (r_cnt != 3'd0) begin
            r_cnt <= r_cnt - 3'd1;
          end else if (r_op == OP_READ) begin
            rsp_valid <= 1'b1;
            rsp_data  <= rf_outa;
            rsp_err   <= 1'b0;
            r_state   <= ST_RESP;
          end else begin
            // MOVE and SWAP both start by writing dst with the value read from src.
            rf_i      <= rf_outa;
            r_b       <= rf_outb;
            rf_funsel <= FS_LOAD;
            if (!r_wp_hit) {rf_regsel, rf_scrsel} <= idx_onehot(r_dst);
            r_state   <= ST_WR_A;
          end
        end

        ST_WR_A: begin
          if (r_op == OP_SWAP) begin
            rf_i <= r_b;
            if (!r_wp_hit) {rf_regsel, rf_scrsel} <= idx_onehot(r_src);
            r_state <= ST_WR_B;
          end else begin
            rsp_valid <= 1'b1;
            rsp_data  <= '0;
            rsp_err   <= r_wp_hit;
            r_state   <= ST_RESP;
          end
        end

        ST_WR_B: begin
          rsp_valid <= 1'b1;
          rsp_data  <= '0;
          rsp_err   <= r_wp_hit;
          r_state   <= ST_RESP;
        end

        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            cmd_ready <= 1'b1;
            r_state   <= ST_IDLE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
